// File: rtl/gpu_command_executor.sv
// Command executor: decodes command words into cursor/colour updates and
// framebuffer pixel writes, rectangle fills and pixel reads.
module gpu_command_executor (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] gpuCommand,
    input  logic [15:0] gpuData,
    input  logic        cmdValid,
    output logic        cmdReady,
    output logic        gpuBusy,
    output logic [15:0] fbAddr,
    output logic [15:0] fbWrData,
    output logic        fbWe,
    output logic        fbRe,
    input  logic        fbWait,
    input  logic [15:0] fbRdData,
    output logic [15:0] dataFromGpu,
    output logic        readValid,
    output logic        cmdError
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        FILL,
        READ_REQ,
        READ_WAIT
    } stateE;

    localparam logic [3:0] OpNop      = 4'h0;
    localparam logic [3:0] OpSetX     = 4'h1;
    localparam logic [3:0] OpSetY     = 4'h2;
    localparam logic [3:0] OpSetColor = 4'h3;
    localparam logic [3:0] OpWrite    = 4'h4;
    localparam logic [3:0] OpFill     = 4'h5;
    localparam logic [3:0] OpRead     = 4'h6;

    stateE       state;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] color;
    logic [7:0]  fx;
    logic [7:0]  fy;
    logic [7:0]  w;
    logic [7:0]  h;
    logic        live;

    logic [3:0]  opcode;
    logic        accept;
    logic [7:0]  fillX;
    logic [7:0]  fillY;
    logic        unusedCmdBits;

    assign opcode        = gpuCommand[15:12];
    assign unusedCmdBits = ^gpuCommand[11:0];
    assign fillX         = x + fx;
    assign fillY         = y + fy;

    // live stays low until the first edge with reset released
    assign cmdReady = live && (state == IDLE);
    assign gpuBusy  = !cmdReady;
    assign accept   = cmdValid && cmdReady;

    // strobes are masked by reset so an aborted operation stops at once
    assign fbWe = rst && !fbWait && ((state == WRITE) || (state == FILL));
    assign fbRe = rst && !fbWait && (state == READ_REQ);

    assign fbAddr   = (state == FILL) ? {fillY, fillX} : {y, x};
    assign fbWrData = color;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            x           <= 8'd0;
            y           <= 8'd0;
            color       <= 16'd0;
            fx          <= 8'd0;
            fy          <= 8'd0;
            w           <= 8'd0;
            h           <= 8'd0;
            dataFromGpu <= 16'd0;
            readValid   <= 1'b0;
            cmdError    <= 1'b0;
            live        <= 1'b0;
        end else begin
            live      <= 1'b1;
            readValid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        unique case (1'b1)
                            (opcode == OpNop): begin
                            end
                            (opcode == OpSetX): x <= gpuData[7:0];
                            (opcode == OpSetY): y <= gpuData[7:0];
                            (opcode == OpSetColor): color <= gpuData;
                            (opcode == OpWrite): state <= WRITE;
                            (opcode == OpFill): begin
                                w     <= gpuData[15:8];
                                h     <= gpuData[7:0];
                                fx    <= 8'd0;
                                fy    <= 8'd0;
                                state <= FILL;
                            end
                            (opcode == OpRead): state <= READ_REQ;
                            default: cmdError <= 1'b1;
                        endcase
                    end
                end
                WRITE: begin
                    if (!fbWait) begin
                        x     <= x + 8'd1;
                        state <= IDLE;
                    end
                end
                FILL: begin
                    if (!fbWait) begin
                        if (fx == w) begin
                            fx <= 8'd0;
                            if (fy == h) begin
                                state <= IDLE;
                            end else begin
                                fy <= fy + 8'd1;
                            end
                        end else begin
                            fx <= fx + 8'd1;
                        end
                    end
                end
                READ_REQ: begin
                    if (!fbWait) begin
                        state <= READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    dataFromGpu <= fbRdData;
                    readValid   <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
